// File: rtl/escalonador_pkg.sv
// Shared definitions for the image resize engine: scale modes, FSM states
// and the geometry helpers that place the scaled image inside the frame.
package escalonador_pkg;

    localparam logic [1:0] MODO_COPIA  = 2'b00;
    localparam logic [1:0] MODO_ZOOM   = 2'b01;
    localparam logic [1:0] MODO_DECIMA = 2'b10;
    localparam logic [1:0] MODO_MEDIA  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NEXT,
        ST_FETCH,
        ST_DRAIN,
        ST_WRITE,
        ST_FIN
    } estado_t;

    // Scaled output extent along one axis (serves both OW and OH).
    function automatic int calc_dim(input int src, input logic [1:0] modo);
        case (modo)
            MODO_COPIA: return src;
            MODO_ZOOM:  return 2 * src;
            default:    return src / 2;
        endcase
    endfunction

    // Centring offset along one axis (serves both OX and OY), floor division.
    function automatic int calc_off(input int dst, input int src, input logic [1:0] modo);
        return (dst - calc_dim(src, modo)) / 2;
    endfunction

endpackage

// File: rtl/escalonador_imagem_gerador_enderecos.sv
// Raster walker: x/y counters, scaled source coordinates kept as a row base
// plus column term, the interior flag and both memory addresses.
module gerador_enderecos
    import escalonador_pkg::*;
#(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int DST_W  = 640,
    parameter int DST_H  = 480,
    parameter int SRC_AW = 17,
    parameter int DST_AW = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              adv,
    input  logic [1:0]        modo,
    input  logic [1:0]        rd_idx,
    output logic              interior,
    output logic              last,
    output logic [SRC_AW-1:0] src_addr,
    output logic [DST_AW-1:0] dst_addr
);

    localparam int XW = $clog2(DST_W + 1);
    localparam int YW = $clog2(DST_H + 1);
    localparam logic [XW-1:0] X_LAST = XW'(DST_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(DST_H - 1);

    logic [XW-1:0]     x_q, x_d, u_q, u_d;
    logic [YW-1:0]     y_q, y_d, v_q, v_d;
    logic [SRC_AW-1:0] row_q, row_d;
    logic [DST_AW-1:0] dst_addr_q, dst_addr_d;
    logic [XW-1:0]     x_ini, x_fim;
    logic [YW-1:0]     y_ini, y_fim;
    logic              x_in, y_in;
    logic [SRC_AW-1:0] sx, row_step, k_off;

    always_comb begin
        x_ini = XW'(calc_off(DST_W, SRC_W, modo));
        x_fim = XW'(calc_off(DST_W, SRC_W, modo) + calc_dim(SRC_W, modo));
        y_ini = YW'(calc_off(DST_H, SRC_H, modo));
        y_fim = YW'(calc_off(DST_H, SRC_H, modo) + calc_dim(SRC_H, modo));
        x_in  = (x_q >= x_ini) && (x_q < x_fim);
        y_in  = (y_q >= y_ini) && (y_q < y_fim);

        sx       = SRC_AW'(u_q);
        row_step = SRC_AW'(SRC_W);
        case (modo)
            MODO_COPIA: begin
                sx       = SRC_AW'(u_q);
                row_step = SRC_AW'(SRC_W);
            end
            MODO_ZOOM: begin
                // Each source row is shown twice: advance only after odd v.
                sx       = SRC_AW'(u_q >> 1);
                row_step = v_q[0] ? SRC_AW'(SRC_W) : '0;
            end
            default: begin
                sx       = SRC_AW'({u_q, 1'b0});
                row_step = SRC_AW'(2 * SRC_W);
            end
        endcase

        // 2x2 block neighbours: bit0 steps right, bit1 steps one row down.
        k_off = (rd_idx[0] ? SRC_AW'(1) : '0) + (rd_idx[1] ? SRC_AW'(SRC_W) : '0);
    end

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        u_d        = u_q;
        v_d        = v_q;
        row_d      = row_q;
        dst_addr_d = dst_addr_q;
        if (clr) begin
            x_d        = '0;
            y_d        = '0;
            u_d        = '0;
            v_d        = '0;
            row_d      = '0;
            dst_addr_d = '0;
        end else if (adv) begin
            dst_addr_d = dst_addr_q + DST_AW'(1);
            if (x_q == X_LAST) begin
                x_d = '0;
                u_d = '0;
                y_d = y_q + YW'(1);
                if (y_in) begin
                    v_d   = v_q + YW'(1);
                    row_d = row_q + row_step;
                end
            end else begin
                x_d = x_q + XW'(1);
                if (x_in) begin
                    u_d = u_q + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q        <= '0;
            y_q        <= '0;
            u_q        <= '0;
            v_q        <= '0;
            row_q      <= '0;
            dst_addr_q <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            u_q        <= u_d;
            v_q        <= v_d;
            row_q      <= row_d;
            dst_addr_q <= dst_addr_d;
        end
    end

    assign interior = x_in && y_in;
    assign last     = (x_q == X_LAST) && (y_q == Y_LAST);
    assign src_addr = row_q + sx + k_off;
    assign dst_addr = dst_addr_q;

endmodule

// File: rtl/escalonador_imagem.sv
// Image resize engine top: start/done handshake, per-pixel FSM and the
// pixel accumulator feeding the frame-buffer write port.
module escalonador_imagem
    import escalonador_pkg::*;
#(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int DST_W  = 640,
    parameter int DST_H  = 480,
    parameter int PIX_W  = 8,
    parameter int SRC_AW = 17,
    parameter int DST_AW = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        modo,
    output logic              busy,
    output logic              done,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [PIX_W-1:0]  src_data,
    output logic [DST_AW-1:0] dst_addr,
    output logic [PIX_W-1:0]  dst_data,
    output logic              dst_wren
);

    estado_t          estado_q, estado_d;
    logic [1:0]       modo_q, modo_d;
    logic [1:0]       rd_idx_q, rd_idx_d;
    logic [PIX_W+1:0] acc_q, acc_d, soma;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dst_wren_q, dst_wren_d;
    logic [PIX_W-1:0] dst_data_q, dst_data_d;
    logic             gen_clr, gen_adv, interior, last;

    gerador_enderecos #(
        .SRC_W  (SRC_W),
        .SRC_H  (SRC_H),
        .DST_W  (DST_W),
        .DST_H  (DST_H),
        .SRC_AW (SRC_AW),
        .DST_AW (DST_AW)
    ) u_gerador (
        .clk      (clk),
        .reset    (reset),
        .clr      (gen_clr),
        .adv      (gen_adv),
        .modo     (modo_q),
        .rd_idx   (rd_idx_q),
        .interior (interior),
        .last     (last),
        .src_addr (src_addr),
        .dst_addr (dst_addr)
    );

    always_comb begin
        estado_d   = estado_q;
        modo_d     = modo_q;
        rd_idx_d   = rd_idx_q;
        acc_d      = acc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dst_wren_d = 1'b0;
        dst_data_d = dst_data_q;
        gen_clr    = 1'b0;
        gen_adv    = 1'b0;
        soma       = acc_q + {2'b00, src_data};

        case (estado_q)
            ST_IDLE: begin
                if (start) begin
                    modo_d   = modo;
                    rd_idx_d = '0;
                    gen_clr  = 1'b1;
                    busy_d   = 1'b1;
                    estado_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                acc_d = '0;
                if (!interior) begin
                    dst_data_d = '0;
                    dst_wren_d = 1'b1;
                    estado_d   = ST_WRITE;
                end else if (modo_q == MODO_MEDIA) begin
                    rd_idx_d = 2'd1;
                    estado_d = ST_FETCH;
                end else begin
                    estado_d = ST_DRAIN;
                end
            end
            ST_FETCH: begin
                // Data returning now belongs to the address issued last cycle.
                acc_d    = soma;
                rd_idx_d = rd_idx_q + 2'd1;
                if (rd_idx_q == 2'd3) begin
                    rd_idx_d = '0;
                    estado_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                dst_data_d = (modo_q == MODO_MEDIA) ? PIX_W'(soma >> 2) : src_data;
                dst_wren_d = 1'b1;
                estado_d   = ST_WRITE;
            end
            ST_WRITE: begin
                if (last) begin
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    estado_d = ST_FIN;
                end else begin
                    gen_adv  = 1'b1;
                    estado_d = ST_NEXT;
                end
            end
            ST_FIN: begin
                estado_d = ST_IDLE;
            end
            default: begin
                estado_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q   <= ST_IDLE;
            modo_q     <= '0;
            rd_idx_q   <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dst_wren_q <= 1'b0;
            dst_data_q <= '0;
        end else begin
            estado_q   <= estado_d;
            modo_q     <= modo_d;
            rd_idx_q   <= rd_idx_d;
            acc_q      <= acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dst_wren_q <= dst_wren_d;
            dst_data_q <= dst_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign dst_wren = dst_wren_q;
    assign dst_data = dst_data_q;

endmodule

// File: tb/tb_escalonador_imagem.sv
// Directed bench for escalonador_imagem on a 4x2 source into an 8x4 frame.
module tb_escalonador_imagem;

    localparam int SW = 4;
    localparam int SH = 2;
    localparam int DW = 8;
    localparam int DH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] modo = 2'b00;
    logic       busy, done, dst_wren;
    logic [2:0] src_addr;
    logic [7:0] src_data;
    logic [4:0] dst_addr;
    logic [7:0] dst_data;

    escalonador_imagem #(
        .SRC_W (SW), .SRC_H (SH), .DST_W (DW), .DST_H (DH),
        .PIX_W (8), .SRC_AW (3), .DST_AW (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .modo     (modo),
        .busy     (busy),
        .done     (done),
        .src_addr (src_addr),
        .src_data (src_data),
        .dst_addr (dst_addr),
        .dst_data (dst_data),
        .dst_wren (dst_wren)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [0:7];
    always @(posedge clk) src_data <= rom[src_addr];

    typedef struct {
        logic [1:0] m;
        int         addr;
        int         val;
    } vec_t;

    typedef struct {
        logic [1:0] m;
        int         lat;
        int         bcyc;
    } fr_t;

    int         n_vec = 0;
    int         n_miss = 0;
    logic [7:0] fb [0:31];
    logic [2:0] asq [0:127];
    int         writes, order_err, done_cnt, done_at, busy_cyc;
    logic       busy_at_done;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic rom_init();
        for (int i = 0; i < 8; i++) rom[i] = 8'(10 * (i + 1));
    endtask

    // Independent geometric model of the scaled, centred frame.
    function automatic int model_px(input int m, input int a);
        int x, y, ow, oh, ox, oy, u, v, s;
        x = a % DW;
        y = a / DW;
        if (m == 0) begin ow = SW; oh = SH; end
        else if (m == 1) begin ow = 2 * SW; oh = 2 * SH; end
        else begin ow = SW / 2; oh = SH / 2; end
        ox = (DW - ow) / 2;
        oy = (DH - oh) / 2;
        if (x < ox || x >= ox + ow || y < oy || y >= oy + oh) return 0;
        u = x - ox;
        v = y - oy;
        case (m)
            0: return int'(rom[v * SW + u]);
            1: return int'(rom[(v / 2) * SW + u / 2]);
            2: return int'(rom[2 * v * SW + 2 * u]);
            default: begin
                s = int'(rom[2 * v * SW + 2 * u]) + int'(rom[2 * v * SW + 2 * u + 1])
                  + int'(rom[(2 * v + 1) * SW + 2 * u]) + int'(rom[(2 * v + 1) * SW + 2 * u + 1]);
                return (s / 4) & 255;
            end
        endcase
    endfunction

    task automatic run_frame(input logic [1:0] m, input int mid_start);
        for (int i = 0; i < 32; i++) fb[i] = 8'hEE;
        writes = 0; order_err = 0; done_cnt = 0; done_at = -1; busy_cyc = 0;
        busy_at_done = 1'b1;
        @(negedge clk); start = 1'b1; modo = m;
        @(negedge clk); start = 1'b0; modo = ~m;
        for (int c = 0; c < 600; c++) begin
            if (busy) busy_cyc++;
            if (c < 128) asq[c] = src_addr;
            if (dst_wren) begin
                if (int'(dst_addr) != writes) order_err++;
                fb[dst_addr] = dst_data;
                writes++;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = c;
                    busy_at_done = busy;
                end
            end
            start = (c == mid_start);
            if (done_at >= 0 && c >= done_at + 10) break;
            @(negedge clk);
        end
        start = 1'b0;
        if (done_at < 0) chk("frame_timeout", 0, 1);
    endtask

    task automatic chk_frame(input string nm, input int m);
        int bad;
        bad = 0;
        for (int a = 0; a < 32; a++)
            if (int'(fb[a]) != model_px(m, a)) bad++;
        chk(nm, bad, 0);
    endtask

    vec_t vt [16];
    fr_t  ft [4];

    initial begin
        int gap, wr2, dn2, bz2;
        bit hit;

        vt[0]  = '{2'b00, 10, 10};  vt[1]  = '{2'b00, 21, 80};
        vt[2]  = '{2'b00, 0, 0};    vt[3]  = '{2'b00, 9, 0};
        vt[4]  = '{2'b00, 13, 40};  vt[5]  = '{2'b00, 18, 50};
        vt[6]  = '{2'b01, 0, 10};   vt[7]  = '{2'b01, 1, 10};
        vt[8]  = '{2'b01, 8, 10};   vt[9]  = '{2'b01, 9, 10};
        vt[10] = '{2'b01, 31, 80};  vt[11] = '{2'b01, 2, 20};
        vt[12] = '{2'b10, 11, 10};  vt[13] = '{2'b10, 12, 30};
        vt[14] = '{2'b10, 19, 0};   vt[15] = '{2'b11, 11, 25};
        ft[0] = '{2'b00, 73, 72};
        ft[1] = '{2'b01, 97, 96};
        ft[2] = '{2'b10, 67, 66};
        ft[3] = '{2'b11, 73, 72};

        rom_init();
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wren", int'(dst_wren), 0);
        chk("rst_src_addr", int'(src_addr), 0);
        chk("rst_dst_addr", int'(dst_addr), 0);
        chk("rst_dst_data", int'(dst_data), 0);

        start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_with_reset_busy", int'(busy), 0);

        for (int f = 0; f < 4; f++) begin
            rom_init();
            if (ft[f].m == 2'b11) begin
                rom[4] = 8'd30;
                rom[5] = 8'd41;
            end
            run_frame(ft[f].m, -1);
            chk($sformatf("m%0d_writes", f), writes, 32);
            chk($sformatf("m%0d_order", f), order_err, 0);
            chk($sformatf("m%0d_latency", f), done_at + 1, ft[f].lat);
            chk($sformatf("m%0d_busy_cycles", f), busy_cyc, ft[f].bcyc);
            chk($sformatf("m%0d_busy_at_done", f), int'(busy_at_done), 0);
            chk($sformatf("m%0d_done_pulses", f), done_cnt, 1);
            chk_frame($sformatf("m%0d_frame_bad_pixels", f), f);
            for (int i = 0; i < 16; i++)
                if (vt[i].m == ft[f].m)
                    chk($sformatf("m%0d_dst%0d", f, vt[i].addr), int'(fb[vt[i].addr]), vt[i].val);
            if (ft[f].m == 2'b11) begin
                chk("avg_src0", int'(asq[22]), 0);
                chk("avg_src1", int'(asq[23]), 1);
                chk("avg_src2", int'(asq[24]), 4);
                chk("avg_src3", int'(asq[25]), 5);
            end
        end

        rom_init();
        run_frame(2'b00, 20);
        chk("midstart_writes", writes, 32);
        chk("midstart_done_pulses", done_cnt, 1);

        // Reset dropped in while the 10th write is on the bus.
        @(negedge clk); start = 1'b1; modo = 2'b00;
        @(negedge clk); start = 1'b0;
        wr2 = 0; hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (dst_wren) wr2++;
            if (wr2 == 10) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        chk("rst_mid_reached_10th", int'(hit), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_outputs", int'({busy, done, dst_wren, src_addr, dst_addr, dst_data}), 0);
        @(negedge clk); reset = 1'b0;
        wr2 = 0; dn2 = 0; bz2 = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (dst_wren) wr2++;
            if (done) dn2++;
            if (busy) bz2++;
        end
        chk("rst_mid_no_writes", wr2, 0);
        chk("rst_mid_no_done", dn2, 0);
        chk("rst_mid_idle", bz2, 0);

        run_frame(2'b00, -1);
        chk("after_rst_writes", writes, 32);
        chk("after_rst_done_pulses", done_cnt, 1);
        chk_frame("after_rst_frame_bad_pixels", 0);

        // start held high across done restarts immediately.
        @(negedge clk); start = 1'b1; modo = 2'b01;
        hit = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) begin hit = 1'b1; break; end
        end
        chk("hold_first_done", int'(hit), 1);
        gap = -1;
        for (int c = 1; c < 6; c++) begin
            @(negedge clk);
            if (busy) begin gap = c; break; end
        end
        start = 1'b0;
        chk("hold_restart_gap", gap, 2);
        hit = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) begin hit = 1'b1; break; end
        end
        chk("hold_second_done", int'(hit), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/escalonador_imagem.md
# escalonador_imagem

Parametrised image-resize engine that sits between the source image ROM and the display frame buffer, driven by the control unit's start/done handshake. On each start it rewrites the entire destination frame in raster order. It produces the source image scaled by one of four modes (1:1 copy, 2x nearest-neighbour zoom, /2 decimation, /2 2x2 block average), centred in the frame, with every border pixel forced to 0. It generalises the fixed 320x240 to 640x480 path to arbitrary sizes and pixel widths, and adds the averaging mode, centring and border clear.

## Interface
- SRC_W, 320, source image width (even, ≥2)
- SRC_H, 240, source image height (even, ≥2)
- DST_W, 640, destination frame width (≥2*SRC_W)
- DST_H, 480, destination frame height (≥2*SRC_H)
- PIX_W, 8, pixel width in bits
- SRC_AW, 17, source address width (2^SRC_AW ≥ SRC_W*SRC_H)
- DST_AW, 19, destination address width (2^DST_AW ≥ DST_W*DST_H)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- modo  in  2  00 copy, 01 zoom x2, 10 decimate /2, 11 average /2; latched at start
- busy  out  1  high while a frame is being produced
- done  out  1  one-cycle pulse after the final write
- src_addr  out  SRC_AW  source ROM address (ROM has 1-cycle read latency)
- src_data  in  PIX_W  source ROM data
- dst_addr  out  DST_AW  frame-buffer write address
- dst_data  out  PIX_W  frame-buffer write data
- dst_wren  out  1  frame-buffer write enable

## Operation
- Output size (OW,OH): copy (SRC_W,SRC_H); zoom (2*SRC_W,2*SRC_H); decimate/average (SRC_W/2,SRC_H/2).
- Offsets: OX=(DST_W-OW)/2 and OY=(DST_H-OH)/2, both using integer floor.
- Pixel (x,y) with OX≤x<OX+OW and OY≤y<OY+OH is interior; all others are border. Let u=x-OX and v=y-OY.
- Source coordinate (sx,sy) for an interior pixel:
  - copy: (u,v)
  - zoom: (u>>1,v>>1)
  - decimate: (2u,2v)
  - average: the four pixels (2u,2v), (2u+1,2v), (2u,2v+1), (2u+1,2v+1), read in that order.
- src_addr=sy*SRC_W+sx and dst_addr=y*DST_W+x. Both are generated by incremental counters and row-base accumulators; no multipliers.
- Average: the sum is PIX_W+2 bits wide; dst_data=sum>>2, truncated.
- Border pixels: dst_data=0. No ROM read is issued for them.
- Each destination address is written exactly once per frame, in raster order: x fastest, then y.
- FSM states:
  - IDLE: on start=1, latch modo, set x=y=0, go to NEXT.
  - NEXT: if the pixel is border, go to WRITE. Otherwise drive the first src_addr and go to FETCH.
  - FETCH: issue the remaining reads (3 more in average mode, 0 otherwise), accumulating returned data. Go to DRAIN.
  - DRAIN: capture the last datum. Go to WRITE.
  - WRITE: assert dst_wren for 1 cycle. If this was the last pixel, go to FIN; else advance x,y and go to NEXT.
  - FIN: pulse done, clear busy, go to IDLE.

## Timing
- Reset value of every output is 0: busy, done, dst_wren, src_addr, dst_addr, dst_data. FSM resets to IDLE.
- Reset asserted mid-frame: immediate return to IDLE, no further writes, no done pulse.
- busy rises in the cycle after start is sampled. It falls in the same cycle done pulses.
- Cycles per destination pixel, counted from entering NEXT to the end of WRITE:
  - border pixel: 2 (NEXT, WRITE)
  - interior pixel, modes 00/01/10: 3 (NEXT, DRAIN, WRITE; FETCH is skipped when there are no extra reads)
  - interior pixel, mode 11: 6 (NEXT, 3 FETCH, DRAIN, WRITE)
- done asserts exactly 1 cycle after the last WRITE.
- start while busy is ignored, as is start coincident with reset. start held high in IDLE immediately after done begins a new frame.
- modo changes during a frame have no effect.

## Structure
- Shared package escalonador_pkg holds:
  - mode constants MODO_COPIA=2'b00, MODO_ZOOM=2'b01, MODO_DECIMA=2'b10, MODO_MEDIA=2'b11
  - FSM state encoding
  - helper functions computing OW, OH, OX, OY from the parameters.
- One sub-module, gerador_enderecos: x/y counters, row-base accumulators, the interior/border flag, src_addr and dst_addr. The top level holds the FSM, the accumulator and the handshake.

## Test plan
All scenarios use SRC_W=4, SRC_H=2, DST_W=8, DST_H=4, PIX_W=8, with ROM[i]=10*(i+1).
- Copy: start with modo=00.
  - 32 writes in raster order.
  - Interior is x=2..5, y=1..2; dst[10]=10 and dst[21]=80. All other addresses are 0.
  - done arrives 24*2+8*3+1=73 cycles after busy rises.
- Zoom: start with modo=01.
  - All 32 addresses are interior; dst[0]=dst[1]=dst[8]=dst[9]=10 and dst[31]=80.
  - 96 pixel cycles.
- Decimate: start with modo=10.
  - Interior is x=3..4, y=1; dst[11]=10, dst[12]=30. All other addresses are 0.
- Average with ROM[0,1,4,5]=10,20,30,41: start with modo=11.
  - dst[11]=25.
  - Exactly 4 consecutive src_addr values are driven, 0,1,4,5.
  - Total = 30*2+2*6 = 72 pixel cycles.
- Handshake and reset:
  - start pulsed again mid-frame: ignored, single done.
  - reset asserted at the 10th write: all outputs 0 next, no done.
  - A later start produces a full 32-write frame.
